// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encodings and counter sizing live here.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fa_df.sv
// Data-flow single-bit full adder.
// Serves as the one-bit datapath slice of the serial adder.
module fa_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock through a single full adder.
// Result is published in one shot when the last bit has been processed.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = clog2(WIDTH);

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ss;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic fa_s;
  logic fa_c;
  logic last;
  logic accept;

  fa_df u_fa (
    .a    (sa[0]),
    .b    (sb[0]),
    .cin  (carry),
    .sum  (fa_s),
    .cout (fa_c)
  );

  assign last   = (cnt == CW'(WIDTH - 1));
  assign accept = start & (state != RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        state_n = start ? RUN : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operands captured only on an accepted start, shifted in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      ss    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      ss    <= {fa_s, ss[WIDTH-1:1]};
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= {fa_s, ss[WIDTH-1:1]};
        cout <= fa_c;
      end
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      ss    <= '0;
      carry <= cin;
      cnt   <= '0;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and table-driven checks for serial_adder (WIDTH=8).
// Stimulus driven and outputs sampled on the falling edge.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int total;
  int passed;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] esum;
    logic         ecout;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ic);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (!done && n < 20) begin
      if (busy) bc++;
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  int n;
  int bc;
  int seen;
  int seed;
  logic [W:0] exp9;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic rc;

  initial begin
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(n, bc);
      chk($sformatf("v%0d_sum", i), {24'd0, sum}, {24'd0, vecs[i].esum});
      chk($sformatf("v%0d_cout", i), {31'd0, cout}, {31'd0, vecs[i].ecout});
      chk($sformatf("v%0d_lat", i), n, W);
      chk($sformatf("v%0d_busy", i), bc, W);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {31'd0, done}, 32'd0);
    end

    // start held during RUN with new operands must be ignored
    start_op(8'h5A, 8'h33, 1'b0);
    start = 1'b1;
    a     = 8'h00;
    b     = 8'h00;
    for (int k = 0; k < 4; k++) @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    chk("ign_sum", {24'd0, sum}, 32'h8D);
    chk("ign_cout", {31'd0, cout}, 32'd0);
    chk("ign_lat", n + 4, W);
    @(negedge clk);

    // back-to-back: restart during the DONE cycle
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(n, bc);
    chk("b2b_first", {24'd0, sum}, 32'hFF);
    start_op(8'h10, 8'h20, 1'b1);
    chk("b2b_nogap", {31'd0, busy}, 32'd1);
    chk("b2b_hold0", {24'd0, sum}, 32'hFF);
    for (int k = 0; k < W - 2; k++) @(negedge clk);
    chk("b2b_hold1", {24'd0, sum}, 32'hFF);
    chk("b2b_cout_hold", {31'd0, cout}, 32'd1);
    wait_done(n, bc);
    chk("b2b_sum", {24'd0, sum}, 32'h31);
    chk("b2b_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);

    // reset while processing bit 4
    start_op(8'hFF, 8'h01, 1'b0);
    for (int k = 0; k < 3; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_sum", {24'd0, sum}, 32'd0);
    chk("mrst_cout", {31'd0, cout}, 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    chk("mrst_nodone", seen, 0);

    // seeded random vectors against a+b+cin
    seed = 32'h1234;
    for (int i = 0; i < 10; i++) begin
      ra   = W'($random(seed));
      rb   = W'($random(seed));
      rc   = 1'($random(seed));
      exp9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      start_op(ra, rb, rc);
      wait_done(n, bc);
      chk($sformatf("rnd%0d", i), {23'd0, cout, sum}, {23'd0, exp9});
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
